conv_window_loader: RTL and testbench
=====================================

# conv_window_loader

Byte-stream front end of the 2x2, 3-channel convolution datapath. It collects filter and image bytes arriving from the SPI receiver on clk_spi into shadow registers, then commits a full 2x5x3 image window and 2x2x3 filter in one cycle onto stable buses driving the convolution core. It flags when the core's registered result is valid.

## Interface
- K, 2, kernel height/width
- C, 3, channels
- W, K+3 = 5, image window columns (4 output positions)
- clk_spi  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- frame_start  in  1  single-cycle pulse at chip-select assertion; starts a new frame
- rx_valid  in  1  rx_data holds a received byte this cycle
- rx_data  in  8  received byte
- image  out  8*K*W*C = 240  committed window; byte idx = c*10 + r*5 + x at bits [8*idx+7 : 8*idx]
- filter  out  8*K*K*C = 96  committed filter; byte idx = c*4 + r*2 + x
- win_valid  out  1  one-cycle pulse in the commit cycle
- conv_valid  out  1  win_valid delayed one cycle; core conv_out valid this cycle
- filt_loaded  out  1  a filter has been committed since reset
- busy  out  1  state != IDLE
- err  out  1  sticky error, cleared on frame_start

## Operation
- States: IDLE, HDR, FILT, IMG, CHK (only with macro), COMMIT. 6-bit byte counter.
- frame_start in any state -> HDR, counter cleared, shadows kept; abort discards the partial frame (outputs unchanged). frame_start with rx_valid same cycle: byte dropped.
- HDR, on byte: bit0=1 -> FILT; bit0=0 and filt_loaded=1 -> IMG; bit0=0 and filt_loaded=0 -> err, IDLE; bits[7:1] != 0 -> err, IDLE.
- FILT: 12 bytes, stored to filter shadow in idx order 0..11, then IMG.
- IMG: 30 bytes to image shadow idx 0..29, then CHK (macro) or COMMIT.
- COMMIT: one cycle; image <= image shadow; filter <= filter shadow only if frame had bit0=1; filt_loaded <= 1 if filter loaded; win_valid=1; -> IDLE.
- Byte arriving in COMMIT: dropped, err set. Bytes in IDLE without frame_start: ignored, no error.
- Image/filter outputs change only in COMMIT; never mid-frame.
- conv_valid registered copy of win_valid.

## Timing
- Reset: image=0, filter=0, win_valid=0, conv_valid=0, filt_loaded=0, busy=0, err=0, state IDLE.
- Last payload (or checksum) byte accepted at edge N -> COMMIT during cycle N+1: new image/filter and win_valid visible after edge N+1; conv_valid after edge N+2.
- Minimum frame: header + 30 bytes (+1 checksum); with filter header + 42 (+1).
- No backpressure: bytes accepted every cycle rx_valid=1.
- Reset mid-frame: immediate return to reset values; partial frame lost.

## Configuration
- CONV_LOADER_CHKSUM_EN defined: after payload, CHK state takes one byte; 8-bit sum (mod 256) of header, payload and checksum byte must be 0 -> COMMIT; else err set, no commit, IDLE.
- Undefined: no CHK state; last payload byte goes straight to COMMIT; no checksum hardware.

## Structure
- Shared package conv_pkg: K, C, W, byte counts (FILT_BYTES=12, IMG_BYTES=30), header bit positions, state enum.
- Sub-module conv_chk8: running 8-bit sum, clear on frame_start, zero-flag output; instantiated only under CONV_LOADER_CHKSUM_EN.

## Test plan
- Reset, then frame header 0x01, filter bytes 1..12, image bytes 0x10..0x2D -> filter byte idx0=0x01, idx11=0x0C; image idx0=0x10, idx29=0x2D; one win_valid, conv_valid next cycle; filt_loaded=1.
- Follow with header 0x00 and 30 bytes of 0xFF -> image all 0xFF, filter unchanged, win_valid once.
- After reset, header 0x00 -> err=1, no win_valid, returns IDLE; next frame_start clears err.
- frame_start after 20 image bytes, then full image-only frame of 0x05 -> image all 0x05, only one win_valid.
- Header 0x82 -> err=1, state IDLE, outputs unchanged.
- With CONV_LOADER_CHKSUM_EN: valid frame with correct checksum commits; same frame with checksum+1 -> err=1, no win_valid, image unchanged.

Source files
------------

// File: rtl/conv_pkg.sv
// conv_pkg: shared geometry, byte counts, header layout and loader states for the conv window loader.
package conv_pkg;
   localparam int K = 2;
   localparam int C = 3;
   localparam int W = K + 3;
   localparam int FILT_BYTES = K * K * C;
   localparam int IMG_BYTES = K * W * C;
   localparam int HDR_FILT_BIT = 0;
   localparam logic [5:0] FILT_LAST = 6'(FILT_BYTES - 1);
   localparam logic [5:0] IMG_LAST = 6'(IMG_BYTES - 1);
   typedef enum logic [2:0] {IDLE, HDR, FILT, IMG, CHK, COMMIT} state_t;
endpackage

// File: rtl/conv_chk8.sv
// conv_chk8: running 8-bit frame sum; zero reports whether sum plus the current byte wraps to 0.
module conv_chk8 (
   input  logic       clk_spi,
   input  logic       rst_n,
   input  logic       clr,
   input  logic       add,
   input  logic [7:0] data,
   output logic       zero
);
   logic [7:0] sum;
   always_ff @(posedge clk_spi or negedge rst_n)
      if (!rst_n) sum <= '0;
      else sum <= clr ? 8'h00 : add ? 8'(sum + data) : sum;
   assign zero = 8'(sum + data) == 8'h00;
endmodule

// File: rtl/conv_window_loader.sv
// conv_window_loader: SPI byte stream -> shadowed 2x5x3 image window and 2x2x3 filter, committed atomically.
// Optional trailing checksum byte enabled by CONV_LOADER_CHKSUM_EN.
module conv_window_loader
   import conv_pkg::*;
(
   input  logic                     clk_spi,
   input  logic                     rst_n,
   input  logic                     frame_start,
   input  logic                     rx_valid,
   input  logic [7:0]               rx_data,
   output logic [8*IMG_BYTES-1:0]   image,
   output logic [8*FILT_BYTES-1:0]  filter,
   output logic                     win_valid,
   output logic                     conv_valid,
   output logic                     filt_loaded,
   output logic                     busy,
   output logic                     err
);
   state_t state, state_nx;
   logic [5:0] cnt;
   logic filt_frame;
   logic [8*IMG_BYTES-1:0] img_sh;
   logic [8*FILT_BYTES-1:0] flt_sh;
   logic take, hdr_ok, chk_ok, err_set, commit;
   assign take = rx_valid && !frame_start;
   assign hdr_ok = rx_data[7:1] == 7'd0 && (rx_data[HDR_FILT_BIT] || filt_loaded);
   assign commit = state == COMMIT && !frame_start;
   assign busy = state != IDLE;
`ifdef CONV_LOADER_CHKSUM_EN
   conv_chk8 u_chk (
      .clk_spi (clk_spi),
      .rst_n   (rst_n),
      .clr     (frame_start),
      .add     (take && (state == HDR || state == FILT || state == IMG)),
      .data    (rx_data),
      .zero    (chk_ok)
   );
`else
   assign chk_ok = 1'b1;
`endif
   assign err_set = take && ((state == HDR && !hdr_ok) || state == COMMIT || (state == CHK && !chk_ok));
   always_ff @(posedge clk_spi or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= state_nx;
   always_comb begin
      state_nx = state;
      if (frame_start) state_nx = HDR;
      else
         case (state)
            HDR:     if (rx_valid) state_nx = !hdr_ok ? IDLE : rx_data[HDR_FILT_BIT] ? FILT : IMG;
            FILT:    if (rx_valid && cnt == FILT_LAST) state_nx = IMG;
`ifdef CONV_LOADER_CHKSUM_EN
            IMG:     if (rx_valid && cnt == IMG_LAST) state_nx = CHK;
`else
            IMG:     if (rx_valid && cnt == IMG_LAST) state_nx = COMMIT;
`endif
            CHK:     if (rx_valid) state_nx = chk_ok ? COMMIT : IDLE;
            COMMIT:  state_nx = IDLE;
            default: state_nx = IDLE;
         endcase
   end
   always_ff @(posedge clk_spi or negedge rst_n)
      if (!rst_n) begin
         cnt         <= '0;
         filt_frame  <= 1'b0;
         img_sh      <= '0;
         flt_sh      <= '0;
         image       <= '0;
         filter      <= '0;
         win_valid   <= 1'b0;
         conv_valid  <= 1'b0;
         filt_loaded <= 1'b0;
         err         <= 1'b0;
      end else begin
         win_valid  <= commit;
         conv_valid <= win_valid;
         err        <= frame_start ? 1'b0 : err | err_set;
         cnt        <= (frame_start || state_nx != state) ? 6'd0 : (take && (state == FILT || state == IMG)) ? cnt + 6'd1 : cnt;
         if (take && state == HDR) filt_frame <= rx_data[HDR_FILT_BIT];
         if (take && state == FILT) flt_sh[{cnt, 3'b000} +: 8] <= rx_data;
         if (take && state == IMG) img_sh[{cnt, 3'b000} +: 8] <= rx_data;
         // Outputs only move here, so the core never sees a half-loaded frame.
         if (commit) begin
            image <= img_sh;
            if (filt_frame) begin
               filter      <= flt_sh;
               filt_loaded <= 1'b1;
            end
         end
      end
endmodule

// File: tb/tb_conv_window_loader.sv
// tb_conv_window_loader: directed self-checking bench for conv_window_loader (checksum frames under CONV_LOADER_CHKSUM_EN).
module tb_conv_window_loader;
   logic clk_spi = 1'b0;
   logic rst_n = 1'b0;
   logic frame_start = 1'b0;
   logic rx_valid = 1'b0;
   logic [7:0] rx_data = 8'h00;
   logic [239:0] image;
   logic [95:0] filter;
   logic win_valid, conv_valid, filt_loaded, busy, err;
   int checks = 0;
   int errors = 0;
   int wv_cnt = 0;
   int wv_base = 0;
   logic [7:0] csum = 8'h00;
   logic [239:0] exp_i;
   logic [95:0] exp_f;

   conv_window_loader dut (
      .clk_spi     (clk_spi),
      .rst_n       (rst_n),
      .frame_start (frame_start),
      .rx_valid    (rx_valid),
      .rx_data     (rx_data),
      .image       (image),
      .filter      (filter),
      .win_valid   (win_valid),
      .conv_valid  (conv_valid),
      .filt_loaded (filt_loaded),
      .busy        (busy),
      .err         (err)
   );

   always #5 clk_spi = ~clk_spi;
   always @(posedge clk_spi) if (win_valid) wv_cnt <= wv_cnt + 1;

   task automatic check(input string tag, input logic [239:0] obs, input logic [239:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic fs();
      @(negedge clk_spi);
      frame_start = 1'b1;
      rx_valid = 1'b0;
      csum = 8'h00;
      wv_base = wv_cnt;
   endtask

   task automatic send(input logic [7:0] b);
      @(negedge clk_spi);
      frame_start = 1'b0;
      rx_valid = 1'b1;
      rx_data = b;
      csum = csum + b;
   endtask

   task automatic idle();
      @(negedge clk_spi);
      frame_start = 1'b0;
      rx_valid = 1'b0;
   endtask

   task automatic end_payload();
`ifdef CONV_LOADER_CHKSUM_EN
      send(8'h00 - csum);
`endif
   endtask

   task automatic expect_commit(input string tag);
      idle();
      check({tag, "_busy_commit"}, 240'(busy), 240'd1);
      idle();
      check({tag, "_win_valid"}, 240'(win_valid), 240'd1);
      check({tag, "_image"}, image, exp_i);
      check({tag, "_filter"}, 240'(filter), 240'(exp_f));
      idle();
      check({tag, "_conv_valid"}, 240'(conv_valid), 240'd1);
      check({tag, "_win_pulse"}, 240'(win_valid), 240'd0);
      check({tag, "_win_count"}, 240'(wv_cnt - wv_base), 240'd1);
      check({tag, "_busy_idle"}, 240'(busy), 240'd0);
   endtask

   initial begin
      repeat (2) @(negedge clk_spi);
      check("rst_image", image, 240'd0);
      check("rst_filter", 240'(filter), 240'd0);
      check("rst_flags", 240'({win_valid, conv_valid, filt_loaded, busy, err}), 240'd0);
      rst_n = 1'b1;
      // filter 1..12, image 0x10..0x2D
      for (int i = 0; i < 12; i++) exp_f[8*i +: 8] = 8'(i + 1);
      for (int i = 0; i < 30; i++) exp_i[8*i +: 8] = 8'(i + 16);
      fs();
      send(8'h01);
      for (int i = 0; i < 12; i++) send(8'(i + 1));
      for (int i = 0; i < 30; i++) send(8'(i + 16));
      end_payload();
      expect_commit("full");
      check("full_filt_idx0", 240'(filter[7:0]), 240'h01);
      check("full_filt_idx11", 240'(filter[95:88]), 240'h0C);
      check("full_img_idx0", 240'(image[7:0]), 240'h10);
      check("full_img_idx29", 240'(image[239:232]), 240'h2D);
      check("full_filt_loaded", 240'(filt_loaded), 240'd1);
      check("full_err", 240'(err), 240'd0);
      // image-only frame keeps the filter
      fs();
      send(8'h00);
      for (int i = 0; i < 30; i++) send(8'hFF);
      end_payload();
      exp_i = {30{8'hFF}};
      expect_commit("imgonly");
      // abort after 20 image bytes
      fs();
      send(8'h00);
      for (int i = 0; i < 20; i++) send(8'h33);
      idle();
      check("abort_image_stable", image, exp_i);
      check("abort_no_win", 240'(wv_cnt - wv_base), 240'd0);
      fs();
      send(8'h00);
      for (int i = 0; i < 30; i++) send(8'h05);
      end_payload();
      exp_i = {30{8'h05}};
      expect_commit("restart");
      // byte landing in the COMMIT cycle is dropped and flagged
      fs();
      send(8'h00);
      for (int i = 0; i < 30; i++) send(8'h44);
      end_payload();
      send(8'h99);
      idle();
      exp_i = {30{8'h44}};
      check("cbyte_win_valid", 240'(win_valid), 240'd1);
      check("cbyte_image", image, exp_i);
      check("cbyte_err", 240'(err), 240'd1);
      // bad header bits
      fs();
      send(8'h82);
      idle();
      check("h82_err", 240'(err), 240'd1);
      check("h82_busy", 240'(busy), 240'd0);
      repeat (3) idle();
      check("h82_image", image, exp_i);
      check("h82_filter", 240'(filter), 240'(exp_f));
      check("h82_no_win", 240'(wv_cnt - wv_base), 240'd0);
      // idle bytes ignored
      send(8'h01);
      send(8'h07);
      idle();
      check("idle_bytes_busy", 240'(busy), 240'd0);
      check("idle_bytes_err", 240'(err), 240'd1);
      // reset mid-frame
      fs();
      send(8'h01);
      send(8'hAA);
      send(8'hBB);
      idle();
      check("mid_busy", 240'(busy), 240'd1);
      rst_n = 1'b0;
      #1;
      check("midrst_image", image, 240'd0);
      check("midrst_filter", 240'(filter), 240'd0);
      check("midrst_flags", 240'({win_valid, conv_valid, filt_loaded, busy, err}), 240'd0);
      idle();
      rst_n = 1'b1;
      // image-only with no filter loaded
      fs();
      send(8'h00);
      idle();
      check("nofilt_err", 240'(err), 240'd1);
      check("nofilt_busy", 240'(busy), 240'd0);
      repeat (2) idle();
      check("nofilt_no_win", 240'(wv_cnt - wv_base), 240'd0);
      fs();
      idle();
      check("fs_clears_err", 240'(err), 240'd0);
      check("fs_busy", 240'(busy), 240'd1);
`ifdef CONV_LOADER_CHKSUM_EN
      exp_f = '0;
      exp_i = '0;
      fs();
      send(8'h01);
      for (int i = 0; i < 12; i++) send(8'(i + 3));
      for (int i = 0; i < 30; i++) send(8'(i * 7));
      send(8'h01 - csum);
      repeat (3) idle();
      check("badsum_err", 240'(err), 240'd1);
      check("badsum_no_win", 240'(wv_cnt - wv_base), 240'd0);
      check("badsum_image", image, exp_i);
      check("badsum_busy", 240'(busy), 240'd0);
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
